// File: rtl/seq_add_inc_engine.sv
// Sequenced add-then-increment engine: c = a + b + N, occupying N+2 cycles; start ignored while busy (no queueing).
// SEQ_ADD_SAT_EN selects saturation at the result ceiling; undefined (default) wraps to 0. ovf flags either case.
module seq_add_inc_engine #(
    parameter int WIDTH = 4,
    parameter int INC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [INC_W-1:0] i_inc_n,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_c,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_INC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [INC_W-1:0] r_cnt;
    logic [WIDTH:0]   r_c;
    logic             r_ovf;
    logic             w_c_ceil;
    logic [WIDTH:0]   w_c_ceil_val;

    assign w_c_ceil = &r_c;

    // Value written when an increment lands on an all-ones result.
`ifdef SEQ_ADD_SAT_EN
    assign w_c_ceil_val = {(WIDTH+1){1'b1}};
`else
    assign w_c_ceil_val = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_ADD;
            S_ADD:  w_state_nxt = (r_cnt != '0) ? S_INC : S_DONE;
            S_INC:  if (r_cnt == INC_W'(1)) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_cnt <= i_inc_n;
                        r_c   <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_c <= {1'b0, r_a} + {1'b0, r_b};
                end
                S_INC: begin
                    r_cnt <= r_cnt - INC_W'(1);
                    if (w_c_ceil) begin
                        r_c   <= w_c_ceil_val;
                        r_ovf <= 1'b1;
                    end else begin
                        r_c <= r_c + (WIDTH+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);
    assign o_c    = r_c;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_add_inc_engine.sv
// Scoreboard bench for seq_add_inc_engine (WIDTH=4, INC_W=4); honours SEQ_ADD_SAT_EN in its model.
module tb_seq_add_inc_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_a;
    logic [3:0] i_b;
    logic [3:0] i_inc_n;
    logic       o_busy;
    logic       o_done;
    logic [4:0] o_c;
    logic       o_ovf;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb_q[$];

    always #5 clk = ~clk;

    seq_add_inc_engine #(.WIDTH(4), .INC_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_inc_n (i_inc_n),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_c     (o_c),
        .o_ovf   (o_ovf)
    );

    // Reference result {ovf, c} built step by step from the operation description.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
        logic [4:0] c;
        logic       ov;
        c  = {1'b0, a} + {1'b0, b};
        ov = 1'b0;
        for (int k = 0; k < int'(n); k++) begin
            if (c == 5'd31) begin
                ov = 1'b1;
`ifdef SEQ_ADD_SAT_EN
                c = 5'd31;
`else
                c = 5'd0;
`endif
            end else begin
                c = c + 5'd1;
            end
        end
        return {ov, c};
    endfunction

    // Drive a start for one edge (edge 0); returns at the negedge after edge 0.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
        @(negedge clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_inc_n = n;
        sb_q.push_back(model(a, b, n));
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
    endtask

    // Advance negedge by negedge until done is seen; edge_no is the edge count after edge 0.
    task automatic wait_done(input int start_edge, input int lim, output int edge_no, output bit ok);
        ok = 1'b0;
        edge_no = start_edge;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            edge_no++;
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b, input logic [3:0] n);
        int         e;
        bit         ok;
        logic [5:0] exp_r;
        launch(a, b, n);
        total++;
        if (o_busy !== 1'b1 || o_c !== 5'd0) begin
            bad++;
            $display("FAIL %s_edge0 busy=%b c=%0d need busy=1 c=0", name, o_busy, o_c);
        end
        wait_done(0, int'(n) + 6, e, ok);
        exp_r = sb_q.pop_front();
        total++;
        if (!ok || e !== int'(n) + 1) begin
            bad++;
            $display("FAIL %s_done_edge got ok=%0d edge=%0d need edge=%0d", name, ok, e, int'(n) + 1);
        end
        total++;
        if ({o_ovf, o_c} !== exp_r) begin
            bad++;
            $display("FAIL %s_result ovf=%b c=%0d need ovf=%b c=%0d", name, o_ovf, o_c, exp_r[5], exp_r[4:0]);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || {o_ovf, o_c} !== exp_r) begin
            bad++;
            $display("FAIL %s_hold busy=%b done=%b ovf=%b c=%0d need 0 0 %b %0d",
                     name, o_busy, o_done, o_ovf, o_c, exp_r[5], exp_r[4:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_inc_n = '0;
        #12;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_c !== 5'd0 || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b c=%0d ovf=%b need all 0", o_busy, o_done, o_c, o_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [5:0] exp_r;
        launch(4'd1, 4'd2, 4'd1);
        @(negedge clk);
        total++;
        if (o_c !== 5'd3 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_edge1 c=%0d done=%b need c=3 done=0", o_c, o_done);
        end
        @(negedge clk);
        exp_r = sb_q.pop_front();
        total++;
        if (o_done !== 1'b1 || {o_ovf, o_c} !== exp_r) begin
            bad++;
            $display("FAIL basic_done done=%b ovf=%b c=%0d need done=1 ovf=%b c=%0d",
                     o_done, o_ovf, o_c, exp_r[5], exp_r[4:0]);
        end
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle busy=%b done=%b need 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_no_inc();
        run_op("noinc", 4'd7, 4'd9, 4'd0);
    endtask

    task automatic test_ceiling();
        run_op("ceil", 4'd15, 4'd15, 4'd5);
    endtask

    task automatic test_start_ignored();
        int         e;
        bit         ok;
        logic [5:0] exp_r;
        launch(4'd2, 4'd3, 4'd3);
        @(negedge clk);
        i_start = 1'b1; i_a = 4'd9; i_b = 4'd9; i_inc_n = 4'd0;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(2, 8, e, ok);
        exp_r = sb_q.pop_front();
        total++;
        if (!ok || e !== 4 || {o_ovf, o_c} !== exp_r) begin
            bad++;
            $display("FAIL ignore ok=%0d edge=%0d c=%0d ovf=%b need edge=4 c=%0d ovf=%b",
                     ok, e, o_c, o_ovf, exp_r[4:0], exp_r[5]);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_queued busy=%b need 0", o_busy);
        end
        run_op("after_ignore", 4'd3, 4'd4, 4'd2);
    endtask

    task automatic test_abort();
        launch(4'd4, 4'd4, 4'd10);
        repeat (3) @(negedge clk);
        void'(sb_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_c !== 5'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL abort c=%0d busy=%b done=%b ovf=%b need all 0", o_c, o_busy, o_done, o_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            total++;
            if (o_done !== 1'b0) begin
                bad++;
                $display("FAIL abort_done done=%b need 0", o_done);
            end
        end
        run_op("post_abort", 4'd1, 4'd1, 4'd2);
    endtask

    task automatic test_back_to_back();
        int         done_cyc[$];
        int         idle_cnt;
        logic [5:0] exp_r;
        idle_cnt = 0;
        @(negedge clk);
        i_start = 1'b1; i_a = 4'd5; i_b = 4'd6; i_inc_n = 4'd2;
        for (int k = 0; k < 3; k++) sb_q.push_back(model(4'd5, 4'd6, 4'd2));
        for (int cyc = 0; cyc < 30 && done_cyc.size() < 3; cyc++) begin
            @(negedge clk);
            if (done_cyc.size() > 0 && !o_busy) idle_cnt++;
            if (o_done) begin
                done_cyc.push_back(cyc);
                exp_r = sb_q.pop_front();
                total++;
                if ({o_ovf, o_c} !== exp_r) begin
                    bad++;
                    $display("FAIL b2b_result ovf=%b c=%0d need ovf=%b c=%0d",
                             o_ovf, o_c, exp_r[5], exp_r[4:0]);
                end
            end
        end
        i_start = 1'b0;
        total++;
        if (done_cyc.size() !== 3) begin
            bad++;
            $display("FAIL b2b_count got %0d dones need 3", done_cyc.size());
        end else begin
            total++;
            if (done_cyc[1] - done_cyc[0] !== 5 || done_cyc[2] - done_cyc[1] !== 5) begin
                bad++;
                $display("FAIL b2b_spacing got %0d,%0d need 5,5",
                         done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
            total++;
            if (idle_cnt !== 2) begin
                bad++;
                $display("FAIL b2b_idle got %0d idle cycles need 2", idle_cnt);
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() !== 0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL scoreboard_left got %0d entries busy=%b need 0 0", sb_q.size(), o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_inc();
        test_ceiling();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
